aes128_iter_core: RTL and testbench
===================================

Name: aes128_iter_core

Overview:
- Round-folded AES-128 encryption core with a valid/ready handshake on both input and output.
- Parametrised successor to the fully unrolled 10-stage AES-128 pipeline; trades throughput for area by applying ROUNDS_PER_CYCLE rounds per clock.
- Expands the round key on the fly and carries a user tag alongside each block.
- Sits between the block-mode controller (CTR/ECB sequencer) and the output buffer.

Parameters:
- ROUNDS_PER_CYCLE, 1, rounds applied per clock; legal values 1, 2, 5, 10; any other value is an elaboration error.
- TAG_W, 4, width of the opaque tag that travels with each block; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  plaintext/key/tag present
- in_ready  out  1  core can accept a block this cycle
- in_state  in  128  plaintext, FIPS-197 byte order (byte 0 = [127:120])
- in_key  in  128  cipher key, same byte order
- in_tag  in  TAG_W  user tag
- out_valid  out  1  ciphertext present
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext
- out_tag  out  TAG_W  tag of the block in out_data
- busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0. out_data, out_tag, state, key and round counter are cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_r <= in_state^in_key, key_r <= in_key, tag_r <= in_tag, rnd <= 0, go to RUN.
- RUN:
  - Each cycle, apply ROUNDS_PER_CYCLE rounds combinationally.
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: MixColumns omitted.
  - The key schedule advances one step per round; rcon is selected by absolute round index (01,02,04,08,10,20,40,80,1b,36).
  - rnd increments by ROUNDS_PER_CYCLE. When rnd reaches 10: out_data <= result, out_tag <= tag_r, out_valid <= 1, go to DONE.
  - in_ready=0 throughout RUN.
- Latency: accept edge to out_valid high = 10/ROUNDS_PER_CYCLE cycles (10, 5, 2 or 1).
- Throughput: one block per 10/ROUNDS_PER_CYCLE+1 cycles with back-to-back traffic.
- DONE:
  - out_valid=1. out_data and out_tag stay stable until out_ready.
  - in_ready = out_ready, so a new block can be accepted in the same cycle as the output handshake.
  - out_ready and in_valid both high: consume the output and load the new block; go to RUN; out_valid falls next cycle.
  - out_ready high, in_valid low: go to IDLE.
  - out_ready low: hold.
- Inputs are sampled only at the accepting edge. Changes afterwards do not affect the block in flight.
- in_valid while busy and not ready: ignored. The producer holds it per the handshake.
- rst mid-operation: the block is discarded and no output is produced. After release the core is in IDLE with in_ready=1.
- No combinational path from in_* to out_*. The only combinational path is out_ready→in_ready in DONE.

Optional Feature:
- Macro: AES128_ITER_STATS_EN.
- Defined:
  - Adds output blk_count[31:0] and input stats_clr.
  - blk_count increments on every out_valid&out_ready handshake and wraps 0xFFFFFFFF→0.
  - stats_clr is synchronous: clears to 0, and takes priority over a same-cycle increment.
  - rst clears blk_count.
- Undefined: ports and counter are absent. All other behaviour is identical.

Decomposition:
- Package aes128_pkg holds:
  - sbox function;
  - xtime and mix_column functions;
  - the 10-entry rcon constant array;
  - NUM_ROUNDS=10 and BLOCK_W=128 constants;
  - the FSM state enum.
- One sub-module, aes128_round_comb: purely combinational.
  - Inputs: state, round key, round index.
  - Outputs: next state, next round key.
  - Applies the final-round rule when the index is 10.
  - The top instantiates ROUNDS_PER_CYCLE copies in a generate chain.

Test Plan:
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → out_data 3925841d02dc09fbdc118597196a0b32, out_tag = in_tag, out_valid after exactly 10/ROUNDS_PER_CYCLE cycles; run for all four parameter values.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 7 cycles after completion → out_valid, out_data and out_tag remain stable and in_ready=0; release with in_valid=1 → new block accepted on the same edge, throughput 11 cycles/block at R=1.
- Back-to-back streaming of 16 random blocks with random tags and random out_ready → all outputs match the reference model in order, tags preserved.
- Assert rst in the 3rd RUN cycle → out_valid never rises for that block; in_ready=1 in the first cycle after release.
- With AES128_ITER_STATS_EN: 5 handshakes → blk_count=5; stats_clr on the same cycle as a handshake → blk_count=0; preload via force 0xFFFFFFFF then one handshake → 0.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, S-box, MixColumns helpers and FSM state type
// for the round-folded core.
package aes128_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// Valid/ready block interface between the mode sequencer (master) and the
// AES-128 core (slave).
interface aes128_iter_core_if
    import aes128_pkg::*;
#(
    parameter int TAG_W = 4
);

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_state;
    logic [BLOCK_W-1:0] in_key;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_state, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_state, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/aes128_round_comb.sv
// One combinational AES-128 encryption round plus the matching key-schedule
// step; index 10 selects the final round without MixColumns.
module aes128_round_comb
    import aes128_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_roundKey,
    input  logic [3:0]         i_roundIdx,
    output logic [BLOCK_W-1:0] o_state,
    output logic [BLOCK_W-1:0] o_roundKey
);

    logic [3:0]         w_rconSel;
    logic [7:0]         w_rcon;
    logic [31:0]        w_lastWord;
    logic [31:0]        w_subRot;
    logic [31:0]        w_nk0, w_nk1, w_nk2, w_nk3;
    logic               w_final;
    logic [BLOCK_W-1:0] w_sub;
    logic [BLOCK_W-1:0] w_shift;
    logic [BLOCK_W-1:0] w_mix;

    // Round i uses rcon[i-1]; the index is absolute so chained copies agree.
    assign w_rconSel  = i_roundIdx - 4'd1;
    assign w_rcon     = RCON[w_rconSel];
    assign w_lastWord = i_roundKey[31:0];
    assign w_subRot   = {sbox(w_lastWord[23:16]), sbox(w_lastWord[15:8]),
                         sbox(w_lastWord[7:0]),   sbox(w_lastWord[31:24])};

    assign w_nk0 = i_roundKey[127:96] ^ w_subRot ^ {w_rcon, 24'h000000};
    assign w_nk1 = i_roundKey[95:64]  ^ w_nk0;
    assign w_nk2 = i_roundKey[63:32]  ^ w_nk1;
    assign w_nk3 = i_roundKey[31:0]   ^ w_nk2;
    assign o_roundKey = {w_nk0, w_nk1, w_nk2, w_nk3};

    assign w_final = (i_roundIdx == 4'(NUM_ROUNDS));

    // Byte b = 4*col + row sits at [127-8b -: 8]; row r rotates left by r.
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        w_mix   = '0;
        for (int b = 0; b < 16; b++) begin
            w_sub[127 - 8 * b -: 8] = sbox(i_state[127 - 8 * b -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127 - 8 * (4 * c + r) -: 8] =
                    w_sub[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127 - 32 * c -: 32] = w_final ? w_shift[127 - 32 * c -: 32]
                                                : mix_column(w_shift[127 - 32 * c -: 32]);
        end
    end

    assign o_state = w_mix ^ o_roundKey;

endmodule

// File: rtl/aes128_iter_core.sv
// Round-folded AES-128 encryption core, ROUNDS_PER_CYCLE rounds per clock.
// Optional block counter enabled by defining AES128_ITER_STATS_EN.
module aes128_iter_core
    import aes128_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int TAG_W            = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes128_iter_core_if.slave bus,
    output logic              busy
`ifdef AES128_ITER_STATS_EN
    ,
    output logic [31:0]       blk_count,
    input  logic              stats_clr
`endif
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_badRounds
        $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end
    if (TAG_W < 1) begin : g_badTag
        $error("aes128_iter_core: TAG_W must be at least 1");
    end

    localparam logic [3:0] STEP     = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    fsm_state_t         r_fsm;
    fsm_state_t         w_fsmNext;
    logic [BLOCK_W-1:0] r_state;
    logic [BLOCK_W-1:0] r_key;
    logic [TAG_W-1:0]   r_tag;
    logic [3:0]         r_rnd;
    logic [BLOCK_W-1:0] r_outData;
    logic [TAG_W-1:0]   r_outTag;
    logic               w_inReady;
    logic               w_lastStep;
    logic               w_load;

    logic [BLOCK_W-1:0] w_stateChain [ROUNDS_PER_CYCLE+1];
    logic [BLOCK_W-1:0] w_keyChain   [ROUNDS_PER_CYCLE+1];

    assign w_stateChain[0] = r_state;
    assign w_keyChain[0]   = r_key;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [3:0] w_roundIdx;
        assign w_roundIdx = r_rnd + 4'(g + 1);

        aes128_round_comb u_round (
            .i_state    (w_stateChain[g]),
            .i_roundKey (w_keyChain[g]),
            .i_roundIdx (w_roundIdx),
            .o_state    (w_stateChain[g+1]),
            .o_roundKey (w_keyChain[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsmNext;
        end
    end

    // In DONE the output handshake frees the core, so in_ready follows out_ready.
    always_comb begin
        w_fsmNext  = r_fsm;
        w_inReady  = 1'b0;
        w_lastStep = 1'b0;
        case (r_fsm)
            IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) begin
                    w_fsmNext = RUN;
                end
            end
            RUN: begin
                w_lastStep = ((r_rnd + STEP) == LAST_RND);
                if (w_lastStep) begin
                    w_fsmNext = DONE;
                end
            end
            DONE: begin
                w_inReady = bus.out_ready;
                if (bus.out_ready) begin
                    w_fsmNext = bus.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                w_fsmNext = IDLE;
            end
        endcase
    end

    assign w_load = bus.in_valid & w_inReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= '0;
            r_key     <= '0;
            r_tag     <= '0;
            r_rnd     <= '0;
            r_outData <= '0;
            r_outTag  <= '0;
        end else if (w_load) begin
            r_state <= bus.in_state ^ bus.in_key;
            r_key   <= bus.in_key;
            r_tag   <= bus.in_tag;
            r_rnd   <= '0;
        end else if (r_fsm == RUN) begin
            r_state <= w_stateChain[ROUNDS_PER_CYCLE];
            r_key   <= w_keyChain[ROUNDS_PER_CYCLE];
            r_rnd   <= r_rnd + STEP;
            if (w_lastStep) begin
                r_outData <= w_stateChain[ROUNDS_PER_CYCLE];
                r_outTag  <= r_tag;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_fsm == DONE);
    assign bus.out_data  = r_outData;
    assign bus.out_tag   = r_outTag;
    assign busy          = (r_fsm != IDLE);

`ifdef AES128_ITER_STATS_EN
    logic [31:0] r_blkCount;
    logic        w_outFire;

    assign w_outFire = bus.out_valid & bus.out_ready;

    // Clear wins over a same-cycle handshake; the count wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blkCount <= '0;
        end else if (stats_clr) begin
            r_blkCount <= '0;
        end else if (w_outFire) begin
            r_blkCount <= r_blkCount + 32'd1;
        end
    end

    assign blk_count = r_blkCount;
`endif

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: known-answer vectors on all four
// ROUNDS_PER_CYCLE builds, backpressure, streaming, reset and stats counter.
module tb_aes128_iter_core;

   localparam int RPC_TAB [4] = '{1, 2, 5, 10};

   localparam logic [127:0] PT [7] = '{
      128'h3243f6a8885a308d313198a2e0370734,
      128'h00112233445566778899aabbccddeeff,
      128'h00000000000000000000000000000000,
      128'h6bc1bee22e409f96e93d7e117393172a,
      128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h30c81c46a35ce411e5fbc1191a0a52ef,
      128'hf69f2445df4f9b17ad2b417be66c3710
   };
   localparam logic [127:0] KEY [7] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h00000000000000000000000000000000,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h2b7e151628aed2a6abf7158809cf4f3c
   };
   localparam logic [127:0] CT [7] = '{
      128'h3925841d02dc09fbdc118597196a0b32,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
      128'h3ad77bb40d7a3660a89ecaf32466ef97,
      128'hf5d3d58503b9699de785895a96fdbaaf,
      128'h43b1cd7f598ece23881b00e3ed030688,
      128'h7b0c785e27e8ad3f8223207104725dd4
   };

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         inValid = 1'b0;
   logic [127:0] inState = '0;
   logic [127:0] inKey = '0;
   logic [3:0]   inTag = '0;
   logic         outReady = 1'b0;
   logic         statsClr = 1'b0;

   logic [3:0]   vAll;
   logic [3:0]   readyAll;
   logic [3:0]   busyAll;
   logic [127:0] dAll [4];
   logic [3:0]   tAll [4];
`ifdef AES128_ITER_STATS_EN
   logic [31:0]  cntAll [4];
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat;
   int first [4];
   int tStamp [2];
   int nSeen;
   int sent;
   int got;
   int sel;
   int seen;
   bit accepted;
   logic [131:0] sb [$];
   logic [131:0] expEntry;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int RPC = RPC_TAB[gi];

      aes128_iter_core_if #(.TAG_W(4)) bus ();

      assign bus.in_valid  = inValid;
      assign bus.in_state  = inState;
      assign bus.in_key    = inKey;
      assign bus.in_tag    = inTag;
      assign bus.out_ready = outReady;
      assign vAll[gi]      = bus.out_valid;
      assign readyAll[gi]  = bus.in_ready;
      assign dAll[gi]      = bus.out_data;
      assign tAll[gi]      = bus.out_tag;

      aes128_iter_core #(.ROUNDS_PER_CYCLE(RPC), .TAG_W(4)) dut (
         .clk       (clk),
         .rst       (rst),
         .bus       (bus),
         .busy      (busyAll[gi])
`ifdef AES128_ITER_STATS_EN
         ,
         .blk_count (cntAll[gi]),
         .stats_clr (statsClr)
`endif
      );
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents vector v until the R=1 core takes it, then scrambles the inputs.
   task automatic applyStimulus(input int v, input logic [3:0] tag);
      int guard;
      guard = 0;
      inState = PT[v];
      inKey   = KEY[v];
      inTag   = tag;
      inValid = 1'b1;
      #1;
      while (!readyAll[0] && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      checkOutput("acceptInTime", 128'(guard < 200), 128'd1);
      @(negedge clk);
      inValid = 1'b0;
      inState = ~PT[v];
      inKey   = ~KEY[v];
      inTag   = ~tag;
   endtask

   // Waits for the R=1 result, checks it and completes the handshake.
   task automatic waitOutput(input int v, input logic [3:0] tag, input string name,
                             input bit clrAtHs, output int latency);
      int guard;
      guard = 0;
      outReady = 1'b1;
      #1;
      while (!vAll[0] && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      latency = guard;
      checkOutput({name, "_valid"}, 128'(vAll[0]), 128'd1);
      checkOutput({name, "_data"}, dAll[0], CT[v]);
      checkOutput({name, "_tag"}, 128'(tAll[0]), 128'(tag));
      statsClr = clrAtHs;
      @(negedge clk);
      statsClr = 1'b0;
      outReady = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rstInReady", 128'(readyAll[0]), 128'd1);
      checkOutput("rstOutValid", 128'(vAll), 128'd0);
      checkOutput("rstBusy", 128'(busyAll), 128'd0);
      checkOutput("rstOutData", dAll[0], 128'd0);
      checkOutput("rstOutTag", 128'(tAll[0]), 128'd0);
      @(negedge clk);
      rst = 1'b0;

      // App. B on every ROUNDS_PER_CYCLE build, output held to measure latency.
      @(negedge clk);
      inState = PT[0];
      inKey   = KEY[0];
      inTag   = 4'h9;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      inState = '1;
      inKey   = '1;
      for (int d = 0; d < 4; d++) first[d] = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         #1;
         for (int d = 0; d < 4; d++) begin
            if (vAll[d] && first[d] == 0) first[d] = k;
         end
      end
      for (int d = 0; d < 4; d++) begin
         checkOutput($sformatf("latencyR%0d", RPC_TAB[d]), 128'(first[d]), 128'(10 / RPC_TAB[d]));
         checkOutput($sformatf("appB_dataR%0d", RPC_TAB[d]), dAll[d], CT[0]);
         checkOutput($sformatf("appB_tagR%0d", RPC_TAB[d]), 128'(tAll[d]), 128'h9);
      end
      checkOutput("appB_heldValid", 128'(vAll), 128'hf);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      #1;
      checkOutput("appB_drained", 128'(vAll), 128'd0);

      // App. C.1, inputs scrambled right after the accepting edge.
      applyStimulus(1, 4'h3);
      waitOutput(1, 4'h3, "appC1", 1'b0, lat);
      checkOutput("appC1_latency", 128'(lat), 128'd10);

      // Backpressure: result held 7 cycles while a new block waits.
      applyStimulus(0, 4'h5);
      seen = 0;
      while (!vAll[0] && seen < 100) begin
         @(negedge clk);
         #1;
         seen++;
      end
      inState = PT[1];
      inKey   = KEY[1];
      inTag   = 4'h6;
      inValid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         #1;
         checkOutput("bpHoldData", dAll[0], CT[0]);
         checkOutput("bpHoldCtl", 128'({vAll[0], readyAll[0], tAll[0]}), 128'({1'b1, 1'b0, 4'h5}));
      end
      outReady = 1'b1;
      #1;
      checkOutput("bpReadyFollows", 128'(readyAll[0]), 128'd1);
      @(negedge clk);
      inValid = 1'b0;
      inState = '0;
      #1;
      checkOutput("bpValidFalls", 128'({vAll[0], busyAll[0]}), 128'b01);
      waitOutput(1, 4'h6, "bpNext", 1'b0, lat);
      checkOutput("bpNext_latency", 128'(lat), 128'd10);

      // Back-to-back: two consecutive results 11 cycles apart at R=1.
      inState  = PT[2];
      inKey    = KEY[2];
      inTag    = 4'hc;
      inValid  = 1'b1;
      outReady = 1'b1;
      nSeen = 0;
      for (int k = 0; k < 60 && nSeen < 2; k++) begin
         @(negedge clk);
         #1;
         if (vAll[0]) begin
            tStamp[nSeen] = cyc;
            checkOutput("b2b_data", dAll[0], CT[2]);
            nSeen++;
            if (nSeen == 2) inValid = 1'b0;
         end
      end
      checkOutput("b2b_count", 128'(nSeen), 128'd2);
      checkOutput("b2b_period", 128'(tStamp[1] - tStamp[0]), 128'd11);
      @(negedge clk);
      outReady = 1'b0;

      // Streaming 16 blocks with random tags and random out_ready.
      sent = 0;
      got = 0;
      accepted = 1'b0;
      inValid = 1'b0;
      for (int c = 0; c < 3000 && got < 16; c++) begin
         @(negedge clk);
         if (accepted) inValid = 1'b0;
         accepted = 1'b0;
         if (!inValid && sent < 16 && $urandom_range(0, 3) != 0) begin
            sel     = sent % 7;
            inState = PT[sel];
            inKey   = KEY[sel];
            inTag   = 4'($urandom);
            inValid = 1'b1;
         end
         outReady = 1'($urandom_range(0, 1));
         #1;
         if (vAll[0] && outReady) begin
            if (sb.size() == 0) begin
               checkOutput("strmUnexpected", 128'd1, 128'd0);
            end else begin
               expEntry = sb.pop_front();
               checkOutput("strmData", dAll[0], expEntry[127:0]);
               checkOutput("strmTag", 128'(tAll[0]), 128'(expEntry[131:128]));
            end
            got++;
         end
         if (inValid && readyAll[0]) begin
            sb.push_back({inTag, CT[sel]});
            sent++;
            accepted = 1'b1;
         end
      end
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("strmReceived", 128'(got), 128'd16);

      // Reset in the third RUN cycle discards the block.
      outReady = 1'b1;
      repeat (3) @(negedge clk);
      outReady = 1'b0;
      applyStimulus(1, 4'h7);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rstMidReady", 128'(readyAll[0]), 128'd1);
      checkOutput("rstMidBusy", 128'(busyAll[0]), 128'd0);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         #1;
         if (vAll[0]) seen++;
      end
      checkOutput("rstMidNoOutput", 128'(seen), 128'd0);

`ifdef AES128_ITER_STATS_EN
      // Block counter: five handshakes, clear on a handshake, wrap from all-ones.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i + 2, 4'(i));
         waitOutput(i + 2, 4'(i), "statsBlk", 1'b0, lat);
      end
      #1;
      checkOutput("statsFive", 128'(cntAll[0]), 128'd5);
      applyStimulus(1, 4'h2);
      waitOutput(1, 4'h2, "statsClrBlk", 1'b1, lat);
      #1;
      checkOutput("statsClrWins", 128'(cntAll[0]), 128'd0);
      force g_dut[0].dut.r_blkCount = 32'hffffffff;
      #1;
      release g_dut[0].dut.r_blkCount;
      #1;
      checkOutput("statsPreload", 128'(cntAll[0]), 128'hffffffff);
      applyStimulus(0, 4'h1);
      waitOutput(0, 4'h1, "statsWrapBlk", 1'b0, lat);
      #1;
      checkOutput("statsWrap", 128'(cntAll[0]), 128'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
